timer_compare_pwm: RTL and testbench

- Compare/PWM stage directly downstream of the 16-bit timer; consumes the timer's current count every clock.
- Produces a PWM output, a sticky compare-match flag with interrupt request, and a match-event counter.
- Memory-mapped on the same 13-bit address / 32-bit data bus as the timer, with rd_i/wr_i strobes.

---
 rtl/timer_compare_pwm.sv | 141 ++++++++++++++
 tb/tb_timer_compare_pwm.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/timer_compare_pwm.sv
// timer_compare_pwm: compare/PWM stage downstream of the 16-bit timer.
// Generates a registered PWM output, a sticky match flag with level IRQ,
// and a saturating match-event counter behind a small register bus.
module timer_compare_pwm #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned ADDR_W = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr_bi,
   input  logic [31:0]       data_bi,
   output logic [31:0]       data_bo,
   input  logic              rd_i,
   input  logic              wr_i,
   input  logic [WIDTH-1:0]  t_val_bi,
   output logic              pwm_o,
   output logic              irq_o
);

   localparam logic [ADDR_W-1:0] A_CMP    = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_CCONF  = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8);
   localparam logic [ADDR_W-1:0] A_MCNT   = ADDR_W'(12);

   logic [WIDTH-1:0] r_cmp;
   logic             r_en;
   logic             r_inv;
   logic             r_irq_en;
   logic             r_oneshot;
   logic             r_flag;
   logic [WIDTH-1:0] r_match_cnt;
   logic [WIDTH-1:0] r_t_prev;
   logic [31:0]      r_data;
   logic             r_pwm;
   logic             r_irq;

   logic             w_wr_cmp;
   logic             w_wr_cconf;
   logic             w_wr_status;
   logic             w_wr_mcnt;
   logic             w_ev;
   logic             w_en_next;
   logic             w_inv_next;
   logic             w_irq_en_next;
   logic             w_oneshot_next;
   logic             w_flag_next;
   logic [WIDTH-1:0] w_cnt_next;
   logic [31:0]      w_rdata;
   logic             w_unused_data;

   assign w_unused_data = ^data_bi[31:WIDTH];

   assign w_wr_cmp    = wr_i && (addr_bi == A_CMP);
   assign w_wr_cconf  = wr_i && (addr_bi == A_CCONF);
   assign w_wr_status = wr_i && (addr_bi == A_STATUS);
   assign w_wr_mcnt   = wr_i && (addr_bi == A_MCNT);

   // A stalled timer parked on CMP yields a single event: t_prev must differ.
   assign w_ev = r_en && (t_val_bi == r_cmp) && (t_val_bi != r_t_prev);

   // Next-state for control/status: bus writes win over event-driven updates,
   // except the flag, where a match set beats a same-cycle W1C clear.
   always_comb begin
      w_en_next      = r_en;
      w_inv_next     = r_inv;
      w_irq_en_next  = r_irq_en;
      w_oneshot_next = r_oneshot;
      w_flag_next    = r_flag;
      w_cnt_next     = r_match_cnt;
      if (w_ev && r_oneshot) begin
         w_en_next = 1'b0;
      end
      if (w_wr_cconf) begin
         w_en_next      = data_bi[0];
         w_inv_next     = data_bi[1];
         w_irq_en_next  = data_bi[2];
         w_oneshot_next = data_bi[3];
      end
      if (w_wr_status && data_bi[0]) begin
         w_flag_next = 1'b0;
      end
      if (w_ev) begin
         w_flag_next = 1'b1;
      end
      if (w_wr_mcnt) begin
         w_cnt_next = data_bi[WIDTH-1:0];
      end else if (w_ev && (r_match_cnt != '1)) begin
         w_cnt_next = r_match_cnt + 1'b1;
      end
   end

   // Read mux over current (pre-write) register contents.
   always_comb begin
      w_rdata = '0;
      case (addr_bi)
         A_CMP:    w_rdata = 32'(r_cmp);
         A_CCONF:  w_rdata = {28'd0, r_oneshot, r_irq_en, r_inv, r_en};
         A_STATUS: w_rdata = {30'd0, r_pwm, r_flag};
         A_MCNT:   w_rdata = 32'(r_match_cnt);
         default:  w_rdata = '0;
      endcase
   end

   // All state: registers, PWM, IRQ and read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cmp       <= '0;
         r_en        <= 1'b0;
         r_inv       <= 1'b0;
         r_irq_en    <= 1'b0;
         r_oneshot   <= 1'b0;
         r_flag      <= 1'b0;
         r_match_cnt <= '0;
         r_t_prev    <= '0;
         r_data      <= '0;
         r_pwm       <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         if (w_wr_cmp) begin
            r_cmp <= data_bi[WIDTH-1:0];
         end
         r_en        <= w_en_next;
         r_inv       <= w_inv_next;
         r_irq_en    <= w_irq_en_next;
         r_oneshot   <= w_oneshot_next;
         r_flag      <= w_flag_next;
         r_match_cnt <= w_cnt_next;
         r_t_prev    <= t_val_bi;
         if (rd_i) begin
            r_data <= w_rdata;
         end
         r_pwm <= r_en ? ((t_val_bi < r_cmp) ^ r_inv) : r_inv;
         r_irq <= w_flag_next & w_irq_en_next;
      end
   end

   assign data_bo = r_data;
   assign pwm_o   = r_pwm;
   assign irq_o   = r_irq;

endmodule

// File: tb/tb_timer_compare_pwm.sv
// Directed self-checking bench for timer_compare_pwm.
module tb_timer_compare_pwm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [12:0] addr_bi = '0;
   logic [31:0] data_bi = '0;
   logic [31:0] data_bo;
   logic        rd_i = 1'b0;
   logic        wr_i = 1'b0;
   logic [15:0] t_val_bi = '0;
   logic        pwm_o;
   logic        irq_o;

   int total = 0;
   int bad   = 0;
   logic [31:0] rv;

   timer_compare_pwm #(.WIDTH(16), .ADDR_W(13)) dut (
      .clk      (clk),
      .rst      (rst),
      .addr_bi  (addr_bi),
      .data_bi  (data_bi),
      .data_bo  (data_bo),
      .rd_i     (rd_i),
      .wr_i     (wr_i),
      .t_val_bi (t_val_bi),
      .pwm_o    (pwm_o),
      .irq_o    (irq_o)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [12:0] a, input logic [31:0] d);
      addr_bi = a;
      data_bi = d;
      wr_i    = 1'b1;
      cyc();
      wr_i    = 1'b0;
   endtask

   task automatic rd(input logic [12:0] a, output logic [31:0] v);
      addr_bi = a;
      rd_i    = 1'b1;
      cyc();
      rd_i    = 1'b0;
      v       = data_bo;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset
      cyc();
      cyc();
      rst = 1'b0;
      check("rst_pwm", 32'(pwm_o), 0);
      check("rst_irq", 32'(irq_o), 0);
      rd(0, rv);  check("rst_cmp", rv, 0);
      rd(4, rv);  check("rst_cconf", rv, 0);
      rd(8, rv);  check("rst_status", rv, 0);
      rd(12, rv); check("rst_mcnt", rv, 0);

      // CMP=3, EN|IRQ_EN, timer 0..7 twice
      wr(0, 3);
      wr(4, 5);
      for (int i = 0; i < 16; i++) begin
         t_val_bi = 16'(i % 8);
         cyc();
         check($sformatf("pwm_t%0d", i), 32'(pwm_o), ((i % 8) < 3) ? 1 : 0);
         if (i == 2) check("irq_before", 32'(irq_o), 0);
         if (i == 3) check("irq_after", 32'(irq_o), 1);
      end
      rd(12, rv); check("mcnt_two", rv, 2);
      rd(8, rv);  check("status_flag", rv, 1);

      // stalled timer on CMP: one event only
      t_val_bi = 3;
      for (int i = 0; i < 10; i++) cyc();
      rd(12, rv); check("mcnt_stall", rv, 3);
      wr(8, 1);
      check("irq_cleared", 32'(irq_o), 0);
      rd(8, rv);  check("status_w1c", rv, 0);

      // W1C colliding with event: set wins
      t_val_bi = 2;
      cyc();
      t_val_bi = 3;
      wr(8, 1);
      check("irq_set_wins", 32'(irq_o), 1);
      rd(8, rv);  check("flag_set_wins", rv, 1);
      rd(12, rv); check("mcnt_four", rv, 4);

      // MATCH_CNT write colliding with event: write wins
      t_val_bi = 2;
      cyc();
      t_val_bi = 3;
      wr(12, 32'h10);
      rd(12, rv); check("mcnt_write_wins", rv, 32'h10);

      // one-shot
      wr(8, 1);
      wr(0, 5);
      wr(4, 9);
      wr(12, 0);
      for (int i = 0; i < 20; i++) begin
         t_val_bi = 16'(i % 10);
         cyc();
      end
      rd(12, rv); check("oneshot_mcnt", rv, 1);
      rd(4, rv);  check("oneshot_cconf", rv, 8);
      check("oneshot_pwm", 32'(pwm_o), 0);
      wr(4, 2);
      cyc();
      check("inv_disabled_pwm", 32'(pwm_o), 1);

      // saturation
      wr(4, 1);
      wr(12, 32'hFFFE);
      t_val_bi = 4; cyc();
      t_val_bi = 5; cyc();
      t_val_bi = 4; cyc();
      t_val_bi = 5; cyc();
      rd(12, rv); check("mcnt_sat", rv, 32'hFFFF);

      // upper data bits dropped
      wr(0, 32'hABCD0007);
      rd(0, rv);  check("cmp_trunc", rv, 7);

      // reset mid-operation
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("mid_rst_pwm", 32'(pwm_o), 0);
      check("mid_rst_irq", 32'(irq_o), 0);
      check("mid_rst_dbo", data_bo, 0);
      rd(0, rv);  check("mid_rst_cmp", rv, 0);
      rd(4, rv);  check("mid_rst_cconf", rv, 0);
      rd(8, rv);  check("mid_rst_status", rv, 0);
      rd(12, rv); check("mid_rst_mcnt", rv, 0);

      // read hold, read-during-write, unmapped read/write
      wr(0, 7);
      rd(0, rv);  check("cmp_read", rv, 7);
      cyc();
      check("dbo_hold", data_bo, 7);
      addr_bi = 0;
      data_bi = 9;
      rd_i = 1'b1;
      wr_i = 1'b1;
      cyc();
      rd_i = 1'b0;
      wr_i = 1'b0;
      check("rd_wr_prewrite", data_bo, 7);
      rd(0, rv);  check("cmp_after_rw", rv, 9);
      wr(20, 32'h1234);
      rd(20, rv); check("unmapped_read", rv, 0);
      rd(0, rv);  check("cmp_after_unmapped", rv, 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
